// File: rtl/writeback_port_arbiter_pkg.sv
// Shared writeback definitions: default register-file geometry, the write request
// record and the encoding that names which source owns the write port.
package writeback_port_arbiter_pkg;

  localparam int WB_DATA_WIDTH = 16;
  localparam int WB_ADDR_WIDTH = 3;

  typedef struct packed {
    logic                     en;
    logic [WB_ADDR_WIDTH-1:0] address;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

  typedef enum logic {
    WB_SRC_PIPE = 1'b0,
    WB_SRC_MC   = 1'b1
  } wb_src_e;

endpackage

// File: rtl/writeback_port_arbiter_fifo.sv
// Strictly in-order result buffer for the multi-cycle unit. A push into a full
// buffer is dropped, so callers gate push with !full (no pass-through on full).
module wb_result_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_data = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    // NOTE: every signal gets a default at the top of a comb block so no path leaves it unassigned (no latch).
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/writeback_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, multi-cycle
// results are buffered. Define WB_ARB_BYPASS_EN to let results skip an empty buffer.
module writeback_port_arbiter
  import writeback_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH    = WB_ADDR_WIDTH,
  parameter int MC_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_write_en,
  input  logic [ADDR_WIDTH-1:0] pipe_address,
  input  logic [DATA_WIDTH-1:0] pipe_data,
  input  logic                  mc_valid,
  output logic                  mc_ready,
  input  logic [ADDR_WIDTH-1:0] mc_address,
  input  logic [DATA_WIDTH-1:0] mc_data,
  input  logic                  mc_issue,
  input  logic [ADDR_WIDTH-1:0] mc_issue_address,
  input  logic [ADDR_WIDTH-1:0] query_address_a,
  input  logic [ADDR_WIDTH-1:0] query_address_b,
  output logic                  hazard_stall,
  output logic                  bubble_req,
  output logic                  rf_write_en,
  output logic [ADDR_WIDTH-1:0] rf_address,
  output logic [DATA_WIDTH-1:0] rf_data
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int ENTRY_W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [ADDR_WIDTH-1:0] head_address;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  bypass_take;
  wb_src_e               wb_src;

  logic                  rf_write_en_q, rf_write_en_d;
  logic [ADDR_WIDTH-1:0] rf_address_q,  rf_address_d;
  logic [DATA_WIDTH-1:0] rf_data_q,     rf_data_d;
  logic [NUM_REGS-1:0]   pending_q,     pending_d;
  logic [CNT_W-1:0]      starve_cnt_q,  starve_cnt_d;
  logic                  bubble_req_q,  bubble_req_d;

  assign mc_ready                  = !fifo_full;
  assign {head_address, head_data} = fifo_head;
  assign fifo_push                 = mc_valid && mc_ready && !bypass_take;

  wb_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (MC_FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({mc_address, mc_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Port selection; address/data hold their last value on idle cycles.
  always_comb begin
    wb_src        = WB_SRC_PIPE;
    fifo_pop      = 1'b0;
    bypass_take   = 1'b0;
    rf_write_en_d = 1'b0;
    rf_address_d  = rf_address_q;
    rf_data_d     = rf_data_q;
    if (pipe_write_en) begin
      rf_write_en_d = 1'b1;
      rf_address_d  = pipe_address;
      rf_data_d     = pipe_data;
    end else if (!fifo_empty) begin
      wb_src        = WB_SRC_MC;
      fifo_pop      = 1'b1;
      rf_write_en_d = 1'b1;
      rf_address_d  = head_address;
      rf_data_d     = head_data;
    end
`ifdef WB_ARB_BYPASS_EN
    else if (mc_valid) begin
      wb_src        = WB_SRC_MC;
      bypass_take   = 1'b1;
      rf_write_en_d = 1'b1;
      rf_address_d  = mc_address;
      rf_data_d     = mc_data;
    end
`endif
  end

  // A retiring multi-cycle result clears its bit; a same-cycle issue re-sets it.
  always_comb begin
    pending_d = pending_q;
    if (rf_write_en_d && (wb_src == WB_SRC_MC)) pending_d[rf_address_d] = 1'b0;
    if (mc_issue)                               pending_d[mc_issue_address] = 1'b1;
  end

  assign hazard_stall = pending_q[query_address_a] | pending_q[query_address_b];

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || fifo_pop) begin
      starve_cnt_d = '0;
    end else if (pipe_write_en && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    bubble_req_d = (starve_cnt_d == STARVE_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write_en_q <= 1'b0;
      rf_address_q  <= '0;
      rf_data_q     <= '0;
      pending_q     <= '0;
      starve_cnt_q  <= '0;
      bubble_req_q  <= 1'b0;
    end else begin
      rf_write_en_q <= rf_write_en_d;
      rf_address_q  <= rf_address_d;
      rf_data_q     <= rf_data_d;
      pending_q     <= pending_d;
      starve_cnt_q  <= starve_cnt_d;
      bubble_req_q  <= bubble_req_d;
    end
  end

  assign rf_write_en = rf_write_en_q;
  assign rf_address  = rf_address_q;
  assign rf_data     = rf_data_q;
  assign bubble_req  = bubble_req_q;

endmodule

// File: tb/tb_writeback_port_arbiter.sv
// Scoreboard bench for writeback_port_arbiter; honours WB_ARB_BYPASS_EN when the
// design is built with it.
module tb_writeback_port_arbiter;
  import writeback_port_arbiter_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_write_en;
  logic [AW-1:0] pipe_address;
  logic [DW-1:0] pipe_data;
  logic          mc_valid;
  logic          mc_ready;
  logic [AW-1:0] mc_address;
  logic [DW-1:0] mc_data;
  logic          mc_issue;
  logic [AW-1:0] mc_issue_address;
  logic [AW-1:0] query_address_a;
  logic [AW-1:0] query_address_b;
  logic          hazard_stall;
  logic          bubble_req;
  logic          rf_write_en;
  logic [AW-1:0] rf_address;
  logic [DW-1:0] rf_data;

  always #5 clk = ~clk;

  writeback_port_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .MC_FIFO_DEPTH (DEPTH),
    .STARVE_LIMIT  (LIMIT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pipe_write_en    (pipe_write_en),
    .pipe_address     (pipe_address),
    .pipe_data        (pipe_data),
    .mc_valid         (mc_valid),
    .mc_ready         (mc_ready),
    .mc_address       (mc_address),
    .mc_data          (mc_data),
    .mc_issue         (mc_issue),
    .mc_issue_address (mc_issue_address),
    .query_address_a  (query_address_a),
    .query_address_b  (query_address_b),
    .hazard_stall     (hazard_stall),
    .bubble_req       (bubble_req),
    .rf_write_en      (rf_write_en),
    .rf_address       (rf_address),
    .rf_data          (rf_data)
  );

  int      n_checks = 0;
  int      n_pass   = 0;
  wb_req_t exp_q[$];   // expected rf_* per cycle
  wb_req_t mc_q[$];    // model of buffered multi-cycle results
  int      starve_m = 0;
  logic    acc;
  int      guard;
  int      pushed;
  logic [DW-1:0] pdat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive one cycle, predict the port decision, then compare after the edge.
  task automatic step(input logic pe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                      input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                      output logic consumed);
    wb_req_t e;
    logic    ready_m, was_empty, popped, enq;
    ready_m   = (mc_q.size() < DEPTH);
    check("mc_ready", mc_ready, ready_m);
    was_empty = (mc_q.size() == 0);
    consumed  = mv && ready_m;
    enq       = consumed;
    popped    = 1'b0;
    e         = '{1'b0, 3'd0, 16'd0};
    if (pe) e = '{1'b1, pa, pd};
    else if (!was_empty) begin
      e      = mc_q.pop_front();
      popped = 1'b1;
    end
`ifdef WB_ARB_BYPASS_EN
    else if (mv) begin
      e   = '{1'b1, ma, md};
      enq = 1'b0;
    end
`endif
    exp_q.push_back(e);
    if (enq) mc_q.push_back('{1'b1, ma, md});
    if (was_empty || popped) starve_m = 0;
    else if (pe && starve_m < LIMIT) starve_m++;

    pipe_write_en = pe;
    pipe_address  = pa;
    pipe_data     = pd;
    mc_valid      = mv;
    mc_address    = ma;
    mc_data       = md;
    @(posedge clk);
    #1;
    mc_issue = 1'b0;
    e = exp_q.pop_front();
    check("rf_write_en", rf_write_en, e.en);
    if (e.en) begin
      check("rf_address", rf_address, e.address);
      check("rf_data", rf_data, e.data);
    end
    check("bubble_req", bubble_req, starve_m == LIMIT);
  endtask

  task automatic idle_inputs();
    pipe_write_en = 0; pipe_address = 0; pipe_data = 0;
    mc_valid = 0; mc_address = 0; mc_data = 0;
    mc_issue = 0; mc_issue_address = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mc_q.delete();
    exp_q.delete();
    starve_m = 0;
  endtask

  // Writing a register the multi-cycle unit still owns is illegal.
  always @(negedge clk)
    if (rst === 1'b0 && pipe_write_en === 1'b1)
      assert (!dut.pending_q[pipe_address])
        else $error("illegal pipe write to pending register r%0d", pipe_address);

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    query_address_a = 0;
    query_address_b = 0;
    rst = 1'b1;
    @(posedge clk);
    apply_reset();

    // 1: reset state, issue r5, result returns, hazard drops with the write
    check("rst_rf_write_en", rf_write_en, 0);
    check("rst_rf_address", rf_address, 0);
    check("rst_rf_data", rf_data, 0);
    check("rst_bubble_req", bubble_req, 0);
    check("rst_mc_ready", mc_ready, 1);
    check("rst_hazard", hazard_stall, 0);
    mc_issue = 1; mc_issue_address = 5;
    step(0, 0, 0, 0, 0, 0, acc);
    query_address_a = 5;
    #1;
    check("t1_hazard_set", hazard_stall, 1);
    step(0, 0, 0, 1, 5, 16'h1234, acc);
`ifndef WB_ARB_BYPASS_EN
    check("t1_hazard_wait", hazard_stall, 1);
    step(0, 0, 0, 0, 0, 0, acc);
`endif
    check("t1_rf_address", rf_address, 5);
    check("t1_rf_data", rf_data, 16'h1234);
    check("t1_hazard_clear", hazard_stall, 0);

    // 2: pipe and mc in the same cycle; pipe first, mc next cycle
    step(1, 1, 16'h00AA, 1, 3, 16'h00BB, acc);
    step(0, 0, 0, 0, 0, 0, acc);
    check("t2_second_address", rf_address, 3);

    // 3: pipe writes every cycle, three mc results -> full, starvation bubble
    pushed = 0; guard = 0; pdat = 16'h0100;
    while (starve_m < LIMIT && guard < 20) begin
      step(1, 7, pdat, pushed < 3, AW'(pushed), 16'h0010 + DW'(pushed), acc);
      if (acc) pushed++;
      pdat++;
      guard++;
    end
    check("t3_cycles_to_bubble", guard, 5);
    check("t3_pushes_before_full", pushed, 2);
    check("t3_mc_ready_low", mc_ready, 0);
    check("t3_bubble_set", bubble_req, 1);
    step(0, 0, 0, 1, AW'(pushed), 16'h0010 + DW'(pushed), acc);
    check("t3_full_no_passthrough", acc, 0);
    check("t3_bubble_clear", bubble_req, 0);
    check("t3_mc_ready_back", mc_ready, 1);
    guard = 0;
    while ((pushed < 3 || mc_q.size() > 0) && guard < 20) begin
      step(0, 0, 0, pushed < 3, AW'(pushed), 16'h0010 + DW'(pushed), acc);
      if (acc) pushed++;
      guard++;
    end
    check("t3_drained", mc_q.size(), 0);

    // 4: re-issue of r2 in the cycle the old r2 result retires keeps it pending
    query_address_a = 0;
    mc_issue = 1; mc_issue_address = 2;
    step(0, 0, 0, 0, 0, 0, acc);
`ifdef WB_ARB_BYPASS_EN
    mc_issue = 1; mc_issue_address = 2;
    step(0, 0, 0, 1, 2, 16'h0222, acc);
`else
    step(0, 0, 0, 1, 2, 16'h0222, acc);
    mc_issue = 1; mc_issue_address = 2;
    step(0, 0, 0, 0, 0, 0, acc);
`endif
    check("t4_retire_address", rf_address, 2);
    query_address_b = 2;
    #1;
    check("t4_hazard_kept", hazard_stall, 1);

    // 5: reset with two buffered entries discards them and pending bits
    mc_issue = 1; mc_issue_address = 3;
    step(1, 7, 16'h0700, 1, 0, 16'h0050, acc);
    step(1, 7, 16'h0701, 1, 1, 16'h0051, acc);
    check("t5_full_before_reset", mc_ready, 0);
    apply_reset();
    query_address_a = 3;
    query_address_b = 2;
    #1;
    check("t5_rf_write_en", rf_write_en, 0);
    check("t5_mc_ready", mc_ready, 1);
    check("t5_hazard", hazard_stall, 0);
    check("t5_bubble_req", bubble_req, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, acc);

    // 6: back-to-back results retire in order, one per cycle
    step(0, 0, 0, 1, 4, 16'h0001, acc);
    check("t6_accept0", acc, 1);
    step(0, 0, 0, 1, 6, 16'h0002, acc);
    check("t6_accept1", acc, 1);
    step(0, 0, 0, 1, 4, 16'h0003, acc);
    check("t6_accept2", acc, 1);
    guard = 0;
    while (mc_q.size() > 0 && guard < 10) begin
      step(0, 0, 0, 0, 0, 0, acc);
      guard++;
    end
    check("t6_drained", mc_q.size(), 0);
    check("t6_last_data", rf_data, 16'h0003);
    step(0, 0, 0, 0, 0, 0, acc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
